// File: rtl/lk_kernel_pkg.sv
// Shared types for the pyramidal LK front-end kernels.
// Holds the derivative FSM states, difference modes and width checks.
package lk_kernel_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef enum logic {
        DIFF_HALF = 1'b0,
        DIFF_FULL = 1'b1
    } mode_e;

    // A full difference of two unsigned pixels needs one extra sign bit.
    function automatic bit out_w_ok(input int pix_w, input int out_w);
        return out_w >= pix_w + 1;
    endfunction

endpackage

// File: rtl/col_line_buf.sv
// One image row of pixel storage.
// A single address is shared by the combinational read and the write.
module col_line_buf #(
    parameter int PIX_W = 12,
    parameter int IMG_W = 640,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    input  logic             we,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);

    logic [PIX_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/col_deriv_stream.sv
// Streaming vertical central difference with replicated top/bottom rows.
// Output row r-1 is produced while input row r arrives; the last row drains in FLUSH.
module col_deriv_stream
    import lk_kernel_pkg::*;
#(
    parameter int PIX_W = 12,
    parameter int OUT_W = 16,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_deriv,
    output logic             out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_END = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_END = RW'(IMG_H - 1);

    if (!out_w_ok(PIX_W, OUT_W)) begin : g_bad_out_w
        $error("OUT_W too narrow for PIX_W");
    end

    state_e           state;
    state_e           state_nx;
    mode_e            mode_q;
    logic [CW-1:0]    col;
    logic [CW-1:0]    fcol;
    logic [RW-1:0]    row;
    logic             accept;
    logic             advance;
    logic             load;
    logic [CW-1:0]    addr;
    logic [PIX_W-1:0] cur_rd;
    logic [PIX_W-1:0] prev_rd;
    logic [PIX_W-1:0] p0;
    logic [PIX_W-1:0] p2;
    logic [OUT_W-1:0] a;
    logic [OUT_W-1:0] b;

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        advance  = 1'b0;
        load     = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                if (accept && col == COL_END) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
                accept   = in_valid && in_ready;
                load     = accept;
                if (accept && col == COL_END && row == ROW_END) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: begin
                advance = !out_valid || out_ready;
                load    = advance;
                if (advance && fcol == COL_END) begin
                    state_nx = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    assign addr = (state == FLUSH) ? fcol : col;

    col_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W), .AW(CW)) u_lb_cur (
        .clk   (clk),
        .addr  (addr),
        .we    (accept),
        .wdata (in_pixel),
        .rdata (cur_rd)
    );

    col_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W), .AW(CW)) u_lb_prev (
        .clk   (clk),
        .addr  (addr),
        .we    (accept),
        .wdata (cur_rd),
        .rdata (prev_rd)
    );

    // Output row 0 replicates itself as the row above.
    assign p2 = (state == FLUSH) ? cur_rd : in_pixel;
    assign p0 = (state == RUN && row == RW'(1)) ? cur_rd : prev_rd;

    always_comb begin
        a = OUT_W'(p2);
        b = OUT_W'(p0);
        if (mode_q == DIFF_HALF) begin
            a = a >> 1;
            b = b >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= FILL;
            col    <= '0;
            row    <= '0;
            fcol   <= '0;
            mode_q <= DIFF_HALF;
        end else begin
            state <= state_nx;
            if (accept) begin
                if (state == FILL && col == '0 && row == '0) begin
                    mode_q <= mode_e'(mode);
                end
                if (col == COL_END) begin
                    col <= '0;
                    row <= (row == ROW_END) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (advance) begin
                fcol <= (fcol == COL_END) ? '0 : fcol + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_deriv <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_deriv <= a - b;
            out_last  <= (state == FLUSH) && (fcol == COL_END);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
